// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - five-stage pipeline fetch sequencer with one-entry IF/ID slot and skid buffer
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   pc                            current PC register value
//   pc_en, next_pc                PC register load enable / load value
//   imem_req, imem_addr           instruction memory request and address
//   imem_ack, imem_rdata          instruction memory response and data
//   id_stall                      ID stage cannot take the IF/ID slot
//   redir_valid, redir_target     branch/jump redirect from EX
//   exc_valid, exc_vector         exception redirect (wins over redir)
//   if_valid, if_pc, if_instr     IF/ID slot contents

module fetch_ctrl #(
    parameter int          WIDTH   = 32,
    parameter int unsigned PC_STEP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pc,
    output logic             pc_en,
    output logic [WIDTH-1:0] next_pc,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] imem_rdata,
    input  logic             id_stall,
    input  logic             redir_valid,
    input  logic [WIDTH-1:0] redir_target,
    input  logic             exc_valid,
    input  logic [WIDTH-1:0] exc_vector,
    output logic             if_valid,
    output logic [WIDTH-1:0] if_pc,
    output logic [WIDTH-1:0] if_instr
);

    localparam logic [WIDTH-1:0] STEP = WIDTH'(PC_STEP);

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_FETCH,
        ST_HOLD,
        ST_DROP
    } state_t;

    state_t           state_q, state_d;
    logic             if_valid_q, if_valid_d;
    logic [WIDTH-1:0] if_pc_q, if_pc_d;
    logic [WIDTH-1:0] if_instr_q, if_instr_d;
    logic             buf_valid_q, buf_valid_d;
    logic [WIDTH-1:0] buf_pc_q, buf_pc_d;
    logic [WIDTH-1:0] buf_instr_q, buf_instr_d;
    logic [WIDTH-1:0] addr_q, addr_d;

    logic             redirect;
    logic [WIDTH-1:0] target;
    logic             accept;
    logic             src_valid;
    logic [WIDTH-1:0] src_pc;
    logic [WIDTH-1:0] src_instr;

    always_comb begin
        redirect    = exc_valid | redir_valid;
        target      = exc_valid ? exc_vector : redir_target;
        accept      = !if_valid_q | !id_stall;

        state_d     = state_q;
        pc_en       = 1'b0;
        next_pc     = pc + STEP;
        imem_req    = 1'b0;
        imem_addr   = pc;
        addr_d      = addr_q;
        if_valid_d  = if_valid_q;
        if_pc_d     = if_pc_q;
        if_instr_d  = if_instr_q;
        buf_valid_d = buf_valid_q;
        buf_pc_d    = buf_pc_q;
        buf_instr_d = buf_instr_q;
        src_valid   = 1'b0;
        src_pc      = pc;
        src_instr   = imem_rdata;

        case (state_q)
            ST_BOOT: begin
                // pc resets to -STEP so this increment lands the first fetch at 0
                pc_en   = 1'b1;
                state_d = ST_FETCH;
            end

            ST_FETCH: begin
                imem_req  = 1'b1;
                imem_addr = pc;
                addr_d    = pc;
                if (redirect) begin
                    pc_en   = 1'b1;
                    next_pc = target;
                    // without an ack the old request must stay on the bus until it completes
                    state_d = imem_ack ? ST_FETCH : ST_DROP;
                end else if (imem_ack) begin
                    pc_en = 1'b1;
                    if (accept) begin
                        src_valid = 1'b1;
                        src_pc    = pc;
                        src_instr = imem_rdata;
                    end else begin
                        buf_valid_d = 1'b1;
                        buf_pc_d    = pc;
                        buf_instr_d = imem_rdata;
                        state_d     = ST_HOLD;
                    end
                end
            end

            ST_HOLD: begin
                if (redirect) begin
                    pc_en   = 1'b1;
                    next_pc = target;
                    state_d = ST_FETCH;
                end else if (accept) begin
                    src_valid   = 1'b1;
                    src_pc      = buf_pc_q;
                    src_instr   = buf_instr_q;
                    buf_valid_d = 1'b0;
                    state_d     = ST_FETCH;
                end
            end

            ST_DROP: begin
                // replay the abandoned address; its data is thrown away on ack
                imem_req  = 1'b1;
                imem_addr = addr_q;
                if (redirect) begin
                    pc_en   = 1'b1;
                    next_pc = target;
                end
                if (imem_ack) begin
                    state_d = ST_FETCH;
                end
            end

            default: begin
                state_d = ST_BOOT;
            end
        endcase

        if (state_q != ST_BOOT && redirect) begin
            if_valid_d  = 1'b0;
            buf_valid_d = 1'b0;
        end else if (accept) begin
            if_valid_d = src_valid;
            if (src_valid) begin
                if_pc_d    = src_pc;
                if_instr_d = src_instr;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_BOOT;
            if_valid_q  <= 1'b0;
            if_pc_q     <= '0;
            if_instr_q  <= '0;
            buf_valid_q <= 1'b0;
            buf_pc_q    <= '0;
            buf_instr_q <= '0;
            addr_q      <= '0;
        end else begin
            state_q     <= state_d;
            if_valid_q  <= if_valid_d;
            if_pc_q     <= if_pc_d;
            if_instr_q  <= if_instr_d;
            buf_valid_q <= buf_valid_d;
            buf_pc_q    <= buf_pc_d;
            buf_instr_q <= buf_instr_d;
            addr_q      <= addr_d;
        end
    end

    assign if_valid = if_valid_q;
    assign if_pc    = if_pc_q;
    assign if_instr = if_instr_q;

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Fetch sequencer for the 5-stage pipeline. It drives the PC register's enable and next-PC inputs and runs the req/ack handshake to instruction memory. It fills a one-entry IF/ID slot and holds it under ID stall, using one skid buffer. Branch/jump and exception redirects flush that slot and discard any in-flight fetch.

Parameters:
WIDTH, 32, address/instruction width
PC_STEP, 4, sequential PC increment

Ports:
clk  in  1  clock
rst  in  1  reset
pc  in  WIDTH  current PC register value (resets to 0xFFFF_FFFC)
pc_en  out  1  PC register enable
next_pc  out  WIDTH  PC register next value
imem_req  out  1  fetch request
imem_addr  out  WIDTH  fetch address
imem_ack  in  1  memory response; only valid while imem_req=1
imem_rdata  in  WIDTH  instruction, valid with imem_ack
id_stall  in  1  ID cannot take the IF/ID slot this cycle
redir_valid  in  1  branch/jump redirect from EX
redir_target  in  WIDTH  redirect address
exc_valid  in  1  exception redirect
exc_vector  in  WIDTH  exception handler address
if_valid  out  1  IF/ID slot valid
if_pc  out  WIDTH  PC of slot instruction
if_instr  out  WIDTH  slot instruction

Behaviour:
- Reset is rst, asynchronous, active-high; clock is clk.
- Reset values: state=BOOT, if_valid=0, if_pc=0, if_instr=0, buffer invalid, addr_q=0.
- Combinational outputs in BOOT: imem_req=0, pc_en=1.
- Redirect: redirect = exc_valid | redir_valid. Target = exc_vector if exc_valid, else redir_target (exception wins).
- Redirect is ignored in BOOT.
- Redirect in any other state:
  - pc_en=1, next_pc=target.
  - if_valid<=0 next edge.
  - Skid buffer invalidated.
  - Same-cycle imem_rdata discarded.
- Slot accept: accept = !if_valid | !id_stall.
- Slot update, no redirect:
  - If accept and a source exists (ack in FETCH, or buffer in HOLD): load if_pc/if_instr, if_valid<=1.
  - If accept and no source: if_valid<=0.
  - Otherwise hold.
- BOOT:
  - pc_en=1, next_pc=pc+PC_STEP. PC wraps 0xFFFF_FFFC to 0x0000_0000.
  - Next state FETCH. First fetch is at 0x0.
- FETCH:
  - imem_req=1, imem_addr=pc; addr_q<=pc every cycle.
  - Address is stable until ack because pc changes only on ack or redirect.
  - No ack, no redirect: pc_en=0, stay.
  - Ack, no redirect: pc_en=1, next_pc=pc+PC_STEP.
    - If accept: data to slot, stay FETCH. Back-to-back fetch, 1 instr/cycle with 0-wait memory.
    - Else: data and PC to buffer, go HOLD.
  - Ack and redirect same cycle: data dropped, pc<=target, stay FETCH.
  - Redirect, no ack: go DROP.
- HOLD:
  - imem_req=0, pc_en=0 (pc already advanced).
  - When accept: buffer to slot, go FETCH.
  - Redirect: go FETCH at target.
- DROP:
  - imem_req=1, imem_addr=addr_q. The old request is held stable until ack, per handshake rule.
  - pc_en=0 unless another redirect occurs; then pc<=new target, stay DROP.
  - On ack: rdata discarded, slot untouched by the dropped data, go FETCH.
  - Ack coincident with a new redirect: pc<=new target, go FETCH.
- Handshake: once asserted, imem_req and imem_addr do not change until the ack cycle.
- PC arithmetic is modulo 2^WIDTH.
- Reset mid-transaction (any state): immediate return to BOOT values. The outstanding memory request is abandoned; memory is reset by the same rst.
- Invariants:
  - Slot and buffer never both load from the same ack.
  - An instruction from a pre-redirect address never reaches if_valid=1.

Test Plan:
- Release rst, imem_ack=1 every cycle, rdata=addr|0xA000_0000 -> BOOT cycle pc_en=1, next_pc=0x0. Then imem_addr 0x0,0x4,0x8; if_pc 0x0,0x4,0x8 on consecutive cycles with if_valid=1.
- Ack delayed 3 cycles at addr 0x4 -> imem_req=1, imem_addr=0x4 stable, pc_en=0 for 3 cycles. Ack cycle: next_pc=0x8, if_pc=0x4 next cycle.
- Slot holds 0x4 with id_stall=1, ack for 0x8 -> state HOLD, imem_req=0, pc=0xC, if_pc stays 0x4. Drop id_stall -> if_pc=0x8, then imem_addr=0xC.
- Request to 0x10 outstanding, redir_valid=1 target 0x100 -> pc_en=1, next_pc=0x100, if_valid=0. imem_addr stays 0x10 until ack; that data is never in the slot. Next request is at 0x100.
- exc_valid (vector 0x80) and redir_valid (0x200) same cycle -> next_pc=0x80; no instruction from 0x200 fetched.
- Assert rst while in DROP -> if_valid=0, imem_req=0 immediately. After release: BOOT, then fetch at 0x0.
